// File: rtl/mssd_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : mssd_frame_tx
// Description : MSSD serial framer: start bit, 6-bit {port,len} header, then
//               len payload bytes, all MSB-first. Optional post-frame idle gap
//               is enabled by defining MSSD_TX_GAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mssd_frame_tx #(
  parameter int unsigned BIT_DIV  = 1,
  parameter int unsigned GAP_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frm_start,
  input  logic [1:0] frm_port,
  input  logic [3:0] frm_len,
  output logic       frm_ready,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       so,
  output logic       busy,
  output logic       done,
  output logic       len_err,
  output logic       underrun
);

`ifdef MSSD_TX_GAP_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_HDR, S_DATA, S_GAP} state_t;
  localparam logic [7:0] C_GAP_LAST = 8'(GAP_BITS - 1);
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_HDR, S_DATA} state_t;
`endif

  localparam logic [7:0] C_BIT_LAST = 8'(BIT_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [5:0] hdr_q, hdr_d;
  logic [2:0] hcnt_q, hcnt_d;
  logic [7:0] data_q, data_d;
  logic [2:0] dcnt_q, dcnt_d;
  logic [3:0] len_q, len_d;
  logic [3:0] sent_q, sent_d;
  logic [3:0] fetched_q, fetched_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       done_q, done_d;
  logic       len_err_q, len_err_d;
  logic       underrun_q, underrun_d;
`ifdef MSSD_TX_GAP_EN
  logic [7:0] gcnt_q, gcnt_d;
`endif

  logic w_bit_end;
  logic w_xfer;
  logic w_load;
  logic w_abort;

  assign w_bit_end  = (timer_q == C_BIT_LAST);
  assign frm_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign byte_ready = busy && !hold_full_q && (fetched_q < len_q);
  assign w_xfer     = byte_valid && byte_ready;
  assign done       = done_q;
  assign len_err    = len_err_q;
  assign underrun   = underrun_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = (state_q == S_IDLE || w_bit_end) ? 8'd0 : timer_q + 8'd1;
    hdr_d       = hdr_q;
    hcnt_d      = hcnt_q;
    data_d      = data_q;
    dcnt_d      = dcnt_q;
    len_d       = len_q;
    sent_d      = sent_q;
    fetched_d   = fetched_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    done_d      = 1'b0;
    len_err_d   = 1'b0;
    underrun_d  = 1'b0;
    w_load      = 1'b0;
    w_abort     = 1'b0;
    so          = 1'b1;
`ifdef MSSD_TX_GAP_EN
    gcnt_d      = gcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (frm_start) begin
          if (frm_len != 4'd0) begin
            len_d     = frm_len;
            hdr_d     = {frm_port, frm_len};
            hcnt_d    = 3'd0;
            sent_d    = 4'd0;
            fetched_d = 4'd0;
            state_d   = S_START;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      S_START: begin
        so = 1'b0;
        if (w_bit_end) state_d = S_HDR;
      end
      S_HDR: begin
        so = hdr_q[5];
        if (w_bit_end) begin
          if (hcnt_q == 3'd5) begin
            if (hold_full_q) begin
              w_load  = 1'b1;
              state_d = S_DATA;
            end else begin
              w_abort = 1'b1;
            end
          end else begin
            hdr_d  = {hdr_q[4:0], 1'b0};
            hcnt_d = hcnt_q + 3'd1;
          end
        end
      end
      S_DATA: begin
        so = data_q[7];
        if (w_bit_end) begin
          if (dcnt_q == 3'd7) begin
            if (sent_q == len_q) begin
              done_d  = 1'b1;
`ifdef MSSD_TX_GAP_EN
              gcnt_d  = 8'd0;
              state_d = S_GAP;
`else
              state_d = S_IDLE;
`endif
            end else if (hold_full_q) begin
              w_load = 1'b1;
            end else begin
              w_abort = 1'b1;
            end
          end else begin
            data_d = {data_q[6:0], 1'b0};
            dcnt_d = dcnt_q + 3'd1;
          end
        end
      end
`ifdef MSSD_TX_GAP_EN
      S_GAP: begin
        if (w_bit_end) begin
          if (gcnt_q == C_GAP_LAST) state_d = S_IDLE;
          else                      gcnt_d  = gcnt_q + 8'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // A shifter load consumes the old holding contents before any new byte lands.
    if (w_load) begin
      data_d      = hold_q;
      dcnt_d      = 3'd0;
      sent_d      = sent_q + 4'd1;
      hold_full_d = 1'b0;
    end
    if (w_xfer) begin
      hold_d      = byte_data;
      hold_full_d = 1'b1;
      fetched_d   = fetched_q + 4'd1;
    end
    if (w_abort) begin
      underrun_d  = 1'b1;
      hold_full_d = 1'b0;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q     <= 8'd0;
      hdr_q       <= 6'd0;
      hcnt_q      <= 3'd0;
      data_q      <= 8'd0;
      dcnt_q      <= 3'd0;
      len_q       <= 4'd0;
      sent_q      <= 4'd0;
      fetched_q   <= 4'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      done_q      <= 1'b0;
      len_err_q   <= 1'b0;
      underrun_q  <= 1'b0;
`ifdef MSSD_TX_GAP_EN
      gcnt_q      <= 8'd0;
`endif
    end else begin
      timer_q     <= timer_d;
      hdr_q       <= hdr_d;
      hcnt_q      <= hcnt_d;
      data_q      <= data_d;
      dcnt_q      <= dcnt_d;
      len_q       <= len_d;
      sent_q      <= sent_d;
      fetched_q   <= fetched_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      done_q      <= done_d;
      len_err_q   <= len_err_d;
      underrun_q  <= underrun_d;
`ifdef MSSD_TX_GAP_EN
      gcnt_q      <= gcnt_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mssd_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mssd_frame_tx
// Description : Directed self-checking bench for mssd_frame_tx (BIT_DIV 1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mssd_frame_tx;

  logic       clk;
  logic       rst;
  logic       frm_start, frm_start3;
  logic [1:0] frm_port, frm_port3;
  logic [3:0] frm_len, frm_len3;
  logic       frm_ready, frm_ready3;
  logic [7:0] byte_data, byte_data3;
  logic       byte_valid, byte_valid3;
  logic       byte_ready, byte_ready3;
  logic       so, so3;
  logic       busy, busy3;
  logic       done, done3;
  logic       len_err, len_err3;
  logic       underrun, underrun3;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;
  int xfers3   = 0;
  int x0;

  logic [14:0] exp15;
  logic [22:0] exp23;

  mssd_frame_tx #(.BIT_DIV(1), .GAP_BITS(2)) dut (
    .clk(clk), .rst(rst),
    .frm_start(frm_start), .frm_port(frm_port), .frm_len(frm_len), .frm_ready(frm_ready),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .so(so), .busy(busy), .done(done), .len_err(len_err), .underrun(underrun)
  );

  mssd_frame_tx #(.BIT_DIV(3), .GAP_BITS(2)) dut3 (
    .clk(clk), .rst(rst),
    .frm_start(frm_start3), .frm_port(frm_port3), .frm_len(frm_len3), .frm_ready(frm_ready3),
    .byte_data(byte_data3), .byte_valid(byte_valid3), .byte_ready(byte_ready3),
    .so(so3), .busy(busy3), .done(done3), .len_err(len_err3), .underrun(underrun3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (byte_valid && byte_ready)   xfers  <= xfers + 1;
    if (byte_valid3 && byte_ready3) xfers3 <= xfers3 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    frm_start = 1'b0;  frm_port = 2'd0;  frm_len = 4'd0;  byte_data = 8'd0;  byte_valid = 1'b0;
    frm_start3 = 1'b0; frm_port3 = 2'd0; frm_len3 = 4'd0; byte_data3 = 8'd0; byte_valid3 = 1'b0;
    #3;
    check("rst_so", so, 1);
    check("rst_frm_ready", frm_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_byte_ready", byte_ready, 0);
    check("rst_done", done, 0);
    check("rst_len_err", len_err, 0);
    check("rst_underrun", underrun, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Frame 1: BIT_DIV=1, port 2, len 1, byte A5 preloaded
    frm_port = 2'b10; frm_len = 4'd1; byte_data = 8'hA5; byte_valid = 1'b1;
    x0 = xfers;
    frm_start = 1'b1;
    tick();
    frm_start = 1'b0;
    exp15 = 15'b0_100001_10100101;
    for (int c = 1; c <= 15; c++) begin
      check("t1_so", so, exp15[15-c]);
      if (c == 10) check("t1_byte_ready_low", byte_ready, 0);
      tick();
    end
    check("t1_done", done, 1);
    check("t1_so_idle", so, 1);
    check("t1_frm_ready", frm_ready, 1);
    check("t1_xfers", xfers - x0, 1);
    byte_valid = 1'b0;
    tick();
    check("t1_done_pulse", done, 0);

    // Zero-length request is rejected
    frm_len = 4'd0;
    frm_start = 1'b1;
    tick();
    frm_start = 1'b0;
    check("t3_len_err", len_err, 1);
    check("t3_so", so, 1);
    check("t3_frm_ready", frm_ready, 1);
    check("t3_byte_ready", byte_ready, 0);
    check("t3_busy", busy, 0);
    tick();
    check("t3_len_err_pulse", len_err, 0);

    // Underrun: len 2, only one byte supplied
    frm_port = 2'b11; frm_len = 4'd2; byte_data = 8'h81; byte_valid = 1'b1;
    frm_start = 1'b1;
    tick();
    frm_start = 1'b0;
    tick();
    byte_valid = 1'b0;
    for (int c = 2; c < 15; c++) begin
      if (c == 9) check("t4_byte_ready_high", byte_ready, 1);
      tick();
    end
    check("t4_last_bit", so, 1);
    check("t4_no_underrun_yet", underrun, 0);
    tick();
    check("t4_underrun", underrun, 1);
    check("t4_so", so, 1);
    check("t4_frm_ready", frm_ready, 1);
    check("t4_done", done, 0);
    tick();
    check("t4_underrun_pulse", underrun, 0);
    check("t4_done_after", done, 0);

    // Asynchronous reset during header, then a clean frame
    frm_port = 2'b01; frm_len = 4'd1;
    frm_start = 1'b1;
    tick();
    frm_start = 1'b0;
    tick();
    tick();
    check("t5_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("t5_so_async", so, 1);
    check("t5_busy_async", busy, 0);
    check("t5_frm_ready_async", frm_ready, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    frm_port = 2'b00; frm_len = 4'd1; byte_data = 8'h00; byte_valid = 1'b1;
    frm_start = 1'b1;
    tick();
    frm_start = 1'b0;
    exp15 = 15'b0_000001_00000000;
    for (int c = 1; c <= 15; c++) begin
      check("t5_so", so, exp15[15-c]);
      tick();
    end
    check("t5_done", done, 1);
    byte_valid = 1'b0;
    tick();

    // Back-to-back frames
    frm_port = 2'b10; frm_len = 4'd1; byte_data = 8'h01; byte_valid = 1'b1;
    x0 = xfers;
    frm_start = 1'b1;
    tick();
    frm_start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    check("t6_last_bit", so, 1);
    tick();
    frm_port = 2'b01;
    frm_start = 1'b1;
    check("t6_done", done, 1);
    check("t6_so_16", so, 1);
`ifdef MSSD_TX_GAP_EN
    check("t6_gap_frm_ready", frm_ready, 0);
    check("t6_gap_busy", busy, 1);
    tick();
    check("t6_so_17", so, 1);
    tick();
    check("t6_so_18", so, 1);
    check("t6_frm_ready_18", frm_ready, 1);
`else
    check("t6_frm_ready", frm_ready, 1);
`endif
    tick();
    frm_start = 1'b0;
    check("t6_b2b_start", so, 0);
    check("t6_b2b_busy", busy, 1);
    for (int c = 1; c <= 15; c++) tick();
    check("t6_done_b", done, 1);
    check("t6_xfers", xfers - x0, 2);
    byte_valid = 1'b0;
    tick();

    // BIT_DIV=3: port 1, len 2, bytes 3C, FF
    frm_port3 = 2'b01; frm_len3 = 4'd2; byte_data3 = 8'h3C; byte_valid3 = 1'b1;
    x0 = xfers3;
    frm_start3 = 1'b1;
    tick();
    frm_start3 = 1'b0;
    exp23 = 23'b0_010010_00111100_11111111;
    for (int c = 1; c <= 69; c++) begin
      check("t2_so", so3, exp23[22-(c-1)/3]);
      tick();
      if (c == 1) byte_data3 = 8'hFF;
    end
    check("t2_done", done3, 1);
    check("t2_so_idle", so3, 1);
    check("t2_xfers", xfers3 - x0, 2);
    byte_valid3 = 1'b0;
    tick();
    check("t2_done_pulse", done3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
